// File: rtl/tcdm_mem_pkg.sv
// Shared types and address-decode helpers for the word-interleaved TCDM banks.
// Addresses are byte addresses; the low two bits select a byte and are ignored.
package tcdm_mem_pkg;

   localparam int unsigned TCDM_AW = 32;
   localparam int unsigned TCDM_DW = 32;
   localparam logic        WEN_WRITE = 1'b0;

   typedef logic [TCDM_AW-1:0]   tcdm_addr_t;
   typedef logic [TCDM_DW-1:0]   tcdm_data_t;
   typedef logic [TCDM_DW/8-1:0] tcdm_strb_t;

   function automatic logic [31:0] addr_to_bank(input tcdm_addr_t add, input int unsigned bank_bits);
      logic [31:0] word_s;
      word_s = 32'(add >> 32'd2);
      return word_s & ((32'd1 << bank_bits) - 32'd1);
   endfunction

   // Row bits above the bank depth are dropped, so addresses wrap silently
   function automatic logic [31:0] addr_to_row(input tcdm_addr_t add, input int unsigned bank_bits,
                                               input int unsigned row_bits);
      logic [31:0] word_s;
      word_s = 32'(add >> 32'd2);
      return (word_s >> bank_bits) & ((32'd1 << row_bits) - 32'd1);
   endfunction

endpackage

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, pointer moves past the winner.
// The pointer holds when nothing is granted.
module tcdm_rr_arbiter
   import tcdm_mem_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_r;
   logic [PW-1:0] ptr_nxt_s;
   logic [PW-1:0] idx_s;
   logic [N-1:0]  gnt_s;
   logic          found_s;
   logic          hit_s;

   // Scan requesters starting at the pointer; the first active one wins
   always_comb begin
      gnt_s     = '0;
      ptr_nxt_s = ptr_r;
      found_s   = 1'b0;
      idx_s     = '0;
      hit_s     = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx_s        = PW'((32'(ptr_r) + 32'(i)) % N);
         hit_s        = !found_s && req[idx_s];
         gnt_s[idx_s] = hit_s;
         found_s      = found_s | hit_s;
         ptr_nxt_s    = hit_s ? PW'((32'(idx_s) + 32'd1) % N) : ptr_nxt_s;
      end
   end

   // Pointer register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_r <= '0;
      end else if (found_s) begin
         ptr_r <= ptr_nxt_s;
      end
   end

   assign gnt = gnt_s;

endmodule

// File: rtl/tcdm_banked_mem.sv
// Word-interleaved multi-bank TCDM slave: any master port reaches any bank,
// conflicts resolved per bank by round-robin, single-cycle response latency.
module tcdm_banked_mem
   import tcdm_mem_pkg::*;
#(
   parameter int unsigned MP         = 4,
   parameter int unsigned NB_BANKS   = 4,
   parameter int unsigned BANK_DEPTH = 256,
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [MP-1:0]        tcdm_req,
   output logic [MP-1:0]        tcdm_gnt,
   input  logic [MP*AW-1:0]     tcdm_add,
   input  logic [MP-1:0]        tcdm_wen,
   input  logic [MP*DW/8-1:0]   tcdm_be,
   input  logic [MP*DW-1:0]     tcdm_data,
   output logic [MP*DW-1:0]     tcdm_r_data,
   output logic [MP-1:0]        tcdm_r_valid
);

   localparam int unsigned BW = $clog2(NB_BANKS);
   localparam int unsigned RW = $clog2(BANK_DEPTH);
   localparam int unsigned SW = DW / 8;

   logic [MP-1:0][BW-1:0]       bank_s;
   logic [MP-1:0][RW-1:0]       row_s;
   logic [NB_BANKS-1:0][MP-1:0] bank_gnt_s;
   logic [NB_BANKS-1:0][DW-1:0] bank_rdata_s;
   logic [MP-1:0]               gnt_s;
   logic [MP-1:0]               r_valid_r;
   logic [MP*DW-1:0]            r_data_r;

   // Per-port address decode into bank and row
   always_comb begin
      bank_s = '0;
      row_s  = '0;
      for (int p = 0; p < MP; p++) begin
         bank_s[p] = BW'(addr_to_bank(tcdm_addr_t'(tcdm_add[p*AW +: AW]), BW));
         row_s[p]  = RW'(addr_to_row(tcdm_addr_t'(tcdm_add[p*AW +: AW]), BW, RW));
      end
   end

   for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
      logic [MP-1:0] breq_s;
      logic [MP-1:0] bgnt_s;
      logic [RW-1:0] win_row_s;
      logic          win_we_s;
      logic [SW-1:0] win_be_s;
      logic [DW-1:0] win_data_s;
      logic [DW-1:0] mem_r [BANK_DEPTH];

      // Requests aimed at this bank; reset masks them so no grant can leak out
      always_comb begin
         breq_s = '0;
         for (int p = 0; p < MP; p++) begin
            breq_s[p] = tcdm_req[p] & rst_ni & (bank_s[p] == BW'(b));
         end
      end

      tcdm_rr_arbiter #(.N(MP)) i_arb (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .req    (breq_s),
         .gnt    (bgnt_s)
      );

      assign bank_gnt_s[b] = bgnt_s;

      // One-hot grant makes an AND-OR mux sufficient to pick the winner's fields
      always_comb begin
         win_row_s  = '0;
         win_we_s   = 1'b0;
         win_be_s   = '0;
         win_data_s = '0;
         for (int p = 0; p < MP; p++) begin
            win_row_s  = win_row_s  | (row_s[p] & {RW{bgnt_s[p]}});
            win_we_s   = win_we_s   | (bgnt_s[p] & (tcdm_wen[p] == WEN_WRITE));
            win_be_s   = win_be_s   | (tcdm_be[p*SW +: SW] & {SW{bgnt_s[p]}});
            win_data_s = win_data_s | (tcdm_data[p*DW +: DW] & {DW{bgnt_s[p]}});
         end
      end

      // Byte-masked write port; storage contents survive reset
      always_ff @(posedge clk_i) begin
         if (win_we_s) begin
            for (int k = 0; k < SW; k++) begin
               if (win_be_s[k]) begin
                  mem_r[win_row_s][k*8 +: 8] <= win_data_s[k*8 +: 8];
               end
            end
         end
      end

      assign bank_rdata_s[b] = mem_r[win_row_s];
   end

   // Each port decodes to exactly one bank, so OR-ing per-bank grants is exact
   always_comb begin
      gnt_s = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         gnt_s = gnt_s | bank_gnt_s[b];
      end
   end

   // Response stage: reads capture the pre-write bank word, writes return zero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid_r <= '0;
         r_data_r  <= '0;
      end else begin
         r_valid_r <= gnt_s;
         for (int p = 0; p < MP; p++) begin
            if (gnt_s[p]) begin
               r_data_r[p*DW +: DW] <= (tcdm_wen[p] == WEN_WRITE) ? {DW{1'b0}} : bank_rdata_s[bank_s[p]];
            end
         end
      end
   end

   assign tcdm_gnt     = gnt_s;
   assign tcdm_r_valid = r_valid_r;
   assign tcdm_r_data  = r_data_r;

endmodule
